// File: rtl/led_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : led_pattern_gen                                            |
// | Description : Multi-channel LED pattern generator. A prescaler divides   |
// |               clk down to a TICK_HZ strobe. Each channel is set to off, |
// |               on, blink (runtime half-period in ticks) or PWM breathe.  |
// | Ports       : clk         - board clock, rising edge                     |
// |               rst         - asynchronous, active-high reset              |
// |               mode        - per-channel mode, ch i at [2i+1:2i]          |
// |                             00 off, 01 on, 10 blink, 11 breathe         |
// |               half_period - blink half-period in ticks (0 acts as 1)    |
// |               led         - registered LED drive, 1 = lit                |
// |               tick        - one-cycle strobe at TICK_HZ                  |
// | Options     : LED_BREATHE_EN - when defined, mode 11 is PWM breathe.    |
// |               When undefined, mode 11 is blink with inverted phase and  |
// |               no PWM logic is built.                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module led_pattern_gen #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int CHANNELS = 4,
    parameter int PWM_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [15:0]           half_period,
    output logic [CHANNELS-1:0]   led,
    output logic                  tick
);

    localparam int              c_div      = CLK_HZ / TICK_HZ;
    localparam int              c_pre_w    = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(c_div - 1);

    localparam logic [1:0] c_mode_off   = 2'b00;
    localparam logic [1:0] c_mode_on    = 2'b01;
    localparam logic [1:0] c_mode_blink = 2'b10;

    if (CHANNELS < 1 || CHANNELS > 16 || PWM_BITS < 1 || CLK_HZ < 2 * TICK_HZ) begin : g_param_err
        $error("led_pattern_gen: parameter out of range");
    end

    // ------------------------------------------------------------------
    // Prescaler. tick is registered from the next prescaler value so that
    // it is high exactly while the prescaler holds DIV-1.
    // ------------------------------------------------------------------
    logic [c_pre_w-1:0] r_pre;
    logic [c_pre_w-1:0] w_pre_next;
    logic               r_tick;

    assign w_pre_next = (r_pre == c_pre_last) ? '0 : r_pre + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_pre  <= w_pre_next;
            r_tick <= (w_pre_next == c_pre_last);
        end
    end

    assign tick = r_tick;

    // Terminal count for the blink counter; a half-period of 0 behaves as 1.
    logic [15:0] w_hp_last;
    assign w_hp_last = (half_period == 16'd0) ? 16'd0 : half_period - 16'd1;

`ifdef LED_BREATHE_EN
    localparam logic [PWM_BITS-1:0] c_duty_max = '1;
    localparam logic [1:0]          c_mode_breathe = 2'b11;

    // Shared free-running PWM ramp; only reset clears it.
    logic [PWM_BITS-1:0] r_pwm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Per-channel pattern state
    // ------------------------------------------------------------------
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0]  w_mode;
        logic        w_chg;
        logic        w_blink;
        logic        w_ph_eff;
        logic        w_led_next;
        logic [1:0]  r_mode_q;
        logic [15:0] r_cnt;
        logic        r_ph;
        logic        r_led;

        assign w_mode = mode[2*i +: 2];
        assign w_chg  = (w_mode != r_mode_q);

`ifdef LED_BREATHE_EN
        assign w_blink = (w_mode == c_mode_blink);
`else
        // Mode 11 shares the blink counter and only inverts the output.
        assign w_blink = w_mode[1];
`endif

        // On a mode change the LED follows the freshly cleared state, so a
        // stale phase from the previous mode never leaks out for a cycle.
        assign w_ph_eff = w_chg ? 1'b0 : r_ph;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_mode_q <= c_mode_off;
                r_cnt    <= '0;
                r_ph     <= 1'b0;
            end else begin
                r_mode_q <= w_mode;
                if (w_chg) begin
                    r_cnt <= '0;
                    r_ph  <= 1'b0;
                end else if (r_tick && w_blink) begin
                    // >= rather than == so a lowered half_period toggles on
                    // the next tick instead of wrapping through 65535.
                    if (r_cnt >= w_hp_last) begin
                        r_cnt <= '0;
                        r_ph  <= ~r_ph;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
            end
        end

`ifdef LED_BREATHE_EN
        logic [PWM_BITS-1:0] r_duty;
        logic                r_up;
        logic [PWM_BITS-1:0] w_duty_eff;

        // Triangle duty: the step at an extreme reverses direction and moves
        // away immediately, so neither end is held for two ticks.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_duty <= '0;
                r_up   <= 1'b1;
            end else if (w_chg) begin
                r_duty <= '0;
                r_up   <= 1'b1;
            end else if (r_tick && (w_mode == c_mode_breathe)) begin
                if (r_up) begin
                    if (r_duty == c_duty_max) begin
                        r_up   <= 1'b0;
                        r_duty <= r_duty - 1'b1;
                    end else begin
                        r_duty <= r_duty + 1'b1;
                    end
                end else begin
                    if (r_duty == '0) begin
                        r_up   <= 1'b1;
                        r_duty <= r_duty + 1'b1;
                    end else begin
                        r_duty <= r_duty - 1'b1;
                    end
                end
            end
        end

        assign w_duty_eff = w_chg ? '0 : r_duty;
`endif

        always_comb begin
            w_led_next = 1'b0;
            case (w_mode)
                c_mode_off:   w_led_next = 1'b0;
                c_mode_on:    w_led_next = 1'b1;
                c_mode_blink: w_led_next = w_ph_eff;
`ifdef LED_BREATHE_EN
                default:      w_led_next = (r_pwm < w_duty_eff);
`else
                default:      w_led_next = ~w_ph_eff;
`endif
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_led <= 1'b0;
            end else begin
                r_led <= w_led_next;
            end
        end

        assign led[i] = r_led;
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_led_pattern_gen                                         |
// | Description : Self-checking bench for led_pattern_gen with CLK_HZ=100,   |
// |               TICK_HZ=10 (DIV=10), CHANNELS=4, PWM_BITS=4. A cycle      |
// |               model derived from the behavioural rules is compared on   |
// |               every cycle; directed checks pin hand-computed values.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_led_pattern_gen;

    localparam int DIV        = 10;
    localparam int PWM_PERIOD = 16;
    localparam int DUTY_TOP   = PWM_PERIOD - 1;
`ifdef LED_BREATHE_EN
    localparam bit BREATHE = 1'b1;
`else
    localparam bit BREATHE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mode;
    logic [15:0] half_period;
    logic [3:0] led;
    logic       tick;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    led_pattern_gen #(
        .CLK_HZ   (100),
        .TICK_HZ  (10),
        .CHANNELS (4),
        .PWM_BITS (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .half_period (half_period),
        .led         (led),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: time is counted in clk edges since reset release. Blink is
    // "ticks since last toggle"; breathe duty is a closed-form triangle of
    // the number of ticks spent in the mode.
    // ------------------------------------------------------------------
    int         m_e;
    logic       m_tick;
    int         m_pwm;
    logic [3:0] m_led;
    logic [1:0] m_mq  [4];
    bit         m_ph  [4];
    int         m_pos [4];
    int         m_n   [4];

    function automatic int tri_duty(input int n);
        int t;
        t = n % (2 * DUTY_TOP);
        return (t <= DUTY_TOP) ? t : (2 * DUTY_TOP - t);
    endfunction

    function automatic bit is_blink(input logic [1:0] md);
        return (md == 2'b10) || (!BREATHE && md == 2'b11);
    endfunction

    function automatic logic led_of(input logic [1:0] md, input bit ph, input int n, input int pwm_b);
        case (md)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return ph;
            default: return BREATHE ? (pwm_b < tri_duty(n)) : !ph;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [1:0] md;
        bit         chg;
        bit         te;
        int         pb;
        int         hp;
        if (rst) begin
            m_e    = 0;
            m_tick = 1'b0;
            m_pwm  = 0;
            m_led  = '0;
            for (int c = 0; c < 4; c++) begin
                m_mq[c]  = 2'b00;
                m_ph[c]  = 1'b0;
                m_pos[c] = 0;
                m_n[c]   = 0;
            end
        end else begin
            te     = m_tick;
            pb     = m_pwm;
            m_e    = m_e + 1;
            m_tick = ((m_e % DIV) == DIV - 1);
            m_pwm  = (m_pwm + 1) % PWM_PERIOD;
            hp     = (half_period == 16'd0) ? 1 : int'(half_period);
            for (int c = 0; c < 4; c++) begin
                md  = mode[2*c +: 2];
                chg = (md != m_mq[c]);
                if (chg) begin
                    m_ph[c]  = 1'b0;
                    m_pos[c] = 0;
                    m_n[c]   = 0;
                end
                m_led[c] = led_of(md, m_ph[c], m_n[c], pb);
                if (!chg && te) begin
                    if (is_blink(md)) begin
                        m_pos[c] = m_pos[c] + 1;
                        if (m_pos[c] >= hp) begin
                            m_pos[c] = 0;
                            m_ph[c]  = !m_ph[c];
                        end
                    end else if (md == 2'b11) begin
                        m_n[c] = m_n[c] + 1;
                    end
                end
                m_mq[c] = md;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            if (rst) begin
                chk("rst_led", led, 0);
                chk("rst_tick", tick, 0);
            end else begin
                chk("led", led, m_led);
                chk("tick", tick, m_tick);
            end
        end
    end

    // Advance to the negedge following clk edge number tgt.
    task automatic goto(input int tgt);
        int guard;
        guard = 0;
        while (m_e < tgt && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("goto_reach", m_e, tgt);
    endtask

    initial begin
        int highs;
        rst         = 1'b1;
        mode        = 8'h00;
        half_period = 16'd3;
        @(posedge clk);
        started = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: tick cadence, all LEDs dark.
        goto(8);   chk("tick_e8", tick, 0);
        goto(9);   chk("tick_e9", tick, 1);   chk("idle_led", led, 4'b0000);
        goto(10);  chk("tick_e10", tick, 0);
        goto(19);  chk("tick_e19", tick, 1);

        // ch0 on.
        mode = 8'b00_00_00_01;
        goto(20);  chk("on_led", led, 4'b0001);
        goto(25);  chk("on_hold", led, 4'b0001);

        // ch2 blink, half_period 3: rises after edge 51, falls after 81.
        mode = 8'b00_10_00_01;
        goto(50);  chk("blk_pre_rise", led[2], 0);
        goto(51);  chk("blk_rise", led[2], 1);
        goto(80);  chk("blk_hold", led[2], 1);
        goto(81);  chk("blk_fall", led[2], 0);

        // blink -> on -> blink, re-entry on a tick edge restarts the count.
        goto(94);  mode = 8'b00_01_00_01;
        goto(96);  chk("reent_on", led[2], 1);
        goto(99);  mode = 8'b00_10_00_01;
        goto(100); chk("reent_clr", led[2], 0);
        goto(111); chk("reent_no_toggle", led[2], 0);
        goto(130); chk("reent_pre_rise", led[2], 0);
        goto(131); chk("reent_rise", led[2], 1);

        // half_period 0 behaves as 1: toggle every tick.
        half_period = 16'd0;
        goto(140); chk("hp0_hold", led[2], 1);
        goto(141); chk("hp0_fall", led[2], 0);
        goto(151); chk("hp0_rise", led[2], 1);

        // Lower half_period below the running count: toggle on next tick.
        half_period = 16'd8;
        goto(200); half_period = 16'd2;
        goto(210); chk("lower_hold", led[2], 1);
        goto(211); chk("lower_fall", led[2], 0);

        // ch3 mode 11.
        mode = 8'b11_10_00_01;
        if (BREATHE) begin
            goto(213); chk("br_start", led[3], 0);
            highs = 0;
            for (int e = 291; e <= 300; e++) begin
                goto(e);
                highs += int'(led[3]);
            end
            chk("br_duty8_highs", highs, 6);
        end else begin
            goto(213); chk("inv_start", led[3], 1);
            goto(230); chk("inv_hold", led[3], 1);
            goto(231); chk("inv_fall", led[3], 0);
        end

        // Long run covers the breathe peak and trough against the model.
        goto(560);
        chk("pre_rst_led0", led[0], 1);
        #2 rst = 1'b1;
        #1 chk("async_led", led, 4'b0000);
        chk("async_tick", tick, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        goto(1);   chk("post_on", led[0], 1);
                   chk("post_blk", led[2], 0);
                   chk("post_ch3", led[3], BREATHE ? 1'b0 : 1'b1);
        goto(9);   chk("post_tick", tick, 1);
        goto(20);  chk("post_pre_rise", led[2], 0);
        goto(21);  chk("post_rise", led[2], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
